bcd_updown_counter: RTL and testbench



---
 rtl/bcd_updown_counter.sv | 92 +++++++++
 tb/tb_bcd_updown_counter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// N-digit synchronous BCD up/down counter with clear, clamped parallel load,
// wrap/saturate terminal behaviour and cascade carry/borrow output.
module bcd_updown_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  up_i,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   din_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  tc_o,
  output logic                  cout_o,
  output logic                  load_err_o
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0]    bcd_q, bcd_d;
  logic [W-1:0]    step_val;
  logic [W-1:0]    load_val;
  logic            load_err_q, load_err_d;
  logic            load_bad;
  logic [DIGITS:0] ripple;

  // ripple[k] = every digit below k is at its terminal value for this direction,
  // so digit k steps this cycle; ripple[DIGITS] is the whole-counter terminal flag.
  always_comb begin
    ripple    = '0;
    ripple[0] = 1'b1;
    step_val  = '0;
    load_val  = '0;
    load_bad  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (up_i) begin
        ripple[k+1] = ripple[k] & (bcd_q[4*k +: 4] == 4'd9);
      end else begin
        ripple[k+1] = ripple[k] & (bcd_q[4*k +: 4] == 4'd0);
      end

      if (!ripple[k]) begin
        step_val[4*k +: 4] = bcd_q[4*k +: 4];
      end else if (up_i) begin
        step_val[4*k +: 4] = (bcd_q[4*k +: 4] == 4'd9) ? 4'd0 : bcd_q[4*k +: 4] + 4'd1;
      end else begin
        step_val[4*k +: 4] = (bcd_q[4*k +: 4] == 4'd0) ? 4'd9 : bcd_q[4*k +: 4] - 4'd1;
      end

      if (din_i[4*k +: 4] > 4'd9) begin
        load_val[4*k +: 4] = 4'd9;
        load_bad           = 1'b1;
      end else begin
        load_val[4*k +: 4] = din_i[4*k +: 4];
      end
    end
  end

  assign tc_o   = ripple[DIGITS];
  assign cout_o = en_i & tc_o & ~clr_i & ~load_i;

  always_comb begin
    bcd_d      = bcd_q;
    load_err_d = 1'b0;
    if (clr_i) begin
      bcd_d = '0;
    end else if (load_i) begin
      bcd_d      = load_val;
      load_err_d = load_bad;
    end else if (en_i) begin
      if (!(SATURATE && tc_o)) begin
        bcd_d = step_val;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bcd_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      bcd_q      <= bcd_d;
      load_err_q <= load_err_d;
    end
  end

  assign bcd_o      = bcd_q;
  assign load_err_o = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: 4-digit wrap and saturate variants,
// plus 1-digit and 8-digit instances sharing the same control inputs.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst_n, en, up, clr, load;
  logic [15:0] din16;
  logic [3:0]  din4;
  logic [31:0] din32;
  logic [15:0] bcd0, bcd1;
  logic [3:0]  bcd2;
  logic [31:0] bcd3;
  logic        tc0, tc1, tc2, tc3;
  logic        cout0, cout1, cout2, cout3;
  logic        lerr0, lerr1, lerr2, lerr3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) dut_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
    .din_i(din16), .bcd_o(bcd0), .tc_o(tc0), .cout_o(cout0), .load_err_o(lerr0));

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b1)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
    .din_i(din16), .bcd_o(bcd1), .tc_o(tc1), .cout_o(cout1), .load_err_o(lerr1));

  bcd_updown_counter #(.DIGITS(1), .SATURATE(1'b0)) dut_d1 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
    .din_i(din4), .bcd_o(bcd2), .tc_o(tc2), .cout_o(cout2), .load_err_o(lerr2));

  bcd_updown_counter #(.DIGITS(8), .SATURATE(1'b0)) dut_d8 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
    .din_i(din32), .bcd_o(bcd3), .tc_o(tc3), .cout_o(cout3), .load_err_o(lerr3));

  function automatic logic [15:0] to_bcd4(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
    din16 = '0; din4 = '0; din32 = '0;
    #12;
    vectors++;
    if (bcd0 !== 16'h0000 || bcd1 !== 16'h0000 || bcd2 !== 4'h0 || bcd3 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_bcd: got %h %h %h %h expected all zero", bcd0, bcd1, bcd2, bcd3);
    end
    vectors++;
    if ({lerr0, lerr1, lerr2, lerr3} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_load_err: got %b expected 0000", {lerr0, lerr1, lerr2, lerr3});
    end
    #2 rst_n = 1'b1;
    step();
    vectors++;
    if (bcd0 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_release_hold: got %h expected 0000", bcd0);
    end
  endtask

  task automatic test_up_wrap();
    logic [15:0] exp_bcd;
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      #1;
      vectors++;
      if (cout0 !== (i == 9999) || tc0 !== (i == 9999)) begin
        miscompares++;
        $display("FAIL up_walk_cout at %0d: got cout=%b tc=%b expected %b", i, cout0, tc0, (i == 9999));
      end
      step();
      exp_bcd = to_bcd4((i + 1) % 10000);
      vectors++;
      if (bcd0 !== exp_bcd) begin
        miscompares++;
        $display("FAIL up_walk_bcd at %0d: got %h expected %h", i, bcd0, exp_bcd);
      end
      vectors++;
      if (bcd2 !== 4'((i + 1) % 10)) begin
        miscompares++;
        $display("FAIL d1_walk_bcd at %0d: got %h expected %0d", i, bcd2, (i + 1) % 10);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_down();
    load = 1'b1; din16 = 16'h0100; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    vectors++;
    if (bcd0 !== 16'h0100) begin
      miscompares++;
      $display("FAIL load_0100: got %h expected 0100", bcd0);
    end
    step();
    vectors++;
    if (bcd0 !== 16'h0099) begin
      miscompares++;
      $display("FAIL down_0099: got %h expected 0099", bcd0);
    end
    step();
    vectors++;
    if (bcd0 !== 16'h0098) begin
      miscompares++;
      $display("FAIL down_0098: got %h expected 0098", bcd0);
    end
    en = 1'b0; load = 1'b1; din16 = 16'h0000;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    #1;
    vectors++;
    if (cout0 !== 1'b1 || tc0 !== 1'b1) begin
      miscompares++;
      $display("FAIL down_borrow_cout: got cout=%b tc=%b expected 1 1", cout0, tc0);
    end
    step();
    vectors++;
    if (bcd0 !== 16'h9999) begin
      miscompares++;
      $display("FAIL down_wrap_9999: got %h expected 9999", bcd0);
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    load = 1'b1; din16 = 16'h9998;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    vectors++;
    if (cout1 !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_cout_c1: got %b expected 0", cout1);
    end
    step();
    vectors++;
    if (bcd1 !== 16'h9999) begin
      miscompares++;
      $display("FAIL sat_c1: got %h expected 9999", bcd1);
    end
    vectors++;
    if (cout1 !== 1'b1 || cout0 !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_cout_c2: got sat=%b wrap=%b expected 1 1", cout1, cout0);
    end
    step();
    vectors++;
    if (bcd1 !== 16'h9999 || bcd0 !== 16'h0000) begin
      miscompares++;
      $display("FAIL sat_c2: got sat=%h wrap=%h expected 9999 0000", bcd1, bcd0);
    end
    vectors++;
    if (cout1 !== 1'b1 || tc1 !== 1'b1 || cout0 !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_cout_c3: got cout=%b tc=%b wrapcout=%b expected 1 1 0", cout1, tc1, cout0);
    end
    step();
    vectors++;
    if (bcd1 !== 16'h9999) begin
      miscompares++;
      $display("FAIL sat_c3: got %h expected 9999", bcd1);
    end
    en = 1'b0;
  endtask

  task automatic test_load_err();
    load = 1'b1; din16 = 16'h3A5F;
    step();
    load = 1'b0;
    vectors++;
    if (bcd0 !== 16'h3959 || lerr0 !== 1'b1) begin
      miscompares++;
      $display("FAIL invalid_load: got bcd=%h err=%b expected 3959 1", bcd0, lerr0);
    end
    step();
    vectors++;
    if (bcd0 !== 16'h3959 || lerr0 !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse_end: got bcd=%h err=%b expected 3959 0", bcd0, lerr0);
    end
    load = 1'b1; din16 = 16'h1234;
    step();
    load = 1'b0;
    vectors++;
    if (bcd0 !== 16'h1234 || lerr0 !== 1'b0) begin
      miscompares++;
      $display("FAIL valid_load: got bcd=%h err=%b expected 1234 0", bcd0, lerr0);
    end
  endtask

  task automatic test_priority();
    load = 1'b1; din16 = 16'h0042;
    step();
    clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; din16 = 16'h1234;
    #1;
    vectors++;
    if (cout0 !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_cout: got %b expected 0", cout0);
    end
    step();
    vectors++;
    if (bcd0 !== 16'h0000) begin
      miscompares++;
      $display("FAIL clr_priority: got %h expected 0000", bcd0);
    end
    clr = 1'b0; en = 1'b0; din16 = 16'hF000;
    step();
    clr = 1'b1; load = 1'b1; din16 = 16'hB000;
    vectors++;
    if (lerr0 !== 1'b1) begin
      miscompares++;
      $display("FAIL err_before_clr: got %b expected 1", lerr0);
    end
    step();
    vectors++;
    if (lerr0 !== 1'b0 || bcd0 !== 16'h0000) begin
      miscompares++;
      $display("FAIL clr_over_bad_load: got err=%b bcd=%h expected 0 0000", lerr0, bcd0);
    end
    clr = 1'b0; load = 1'b1; en = 1'b1; din16 = 16'h0007;
    step();
    load = 1'b0; en = 1'b0;
    vectors++;
    if (bcd0 !== 16'h0007) begin
      miscompares++;
      $display("FAIL load_over_en: got %h expected 0007", bcd0);
    end
  endtask

  task automatic test_hold();
    en = 1'b0; up = 1'b0;
    #1;
    vectors++;
    if (tc0 !== 1'b0 || cout0 !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_flags: got tc=%b cout=%b expected 0 0", tc0, cout0);
    end
    step();
    vectors++;
    if (bcd0 !== 16'h0007) begin
      miscompares++;
      $display("FAIL hold_bcd: got %h expected 0007", bcd0);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    #1;
    vectors++;
    if (tc0 !== 1'b1 || cout0 !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_zero_down: got tc=%b cout=%b expected 1 0", tc0, cout0);
    end
    up = 1'b1;
    #1;
    vectors++;
    if (tc0 !== 1'b0) begin
      miscompares++;
      $display("FAIL tc_dir_change: got %b expected 0", tc0);
    end
  endtask

  task automatic test_async_reset();
    load = 1'b1; din16 = 16'h4567; en = 1'b0;
    step();
    load = 1'b0;
    vectors++;
    if (bcd0 !== 16'h4567) begin
      miscompares++;
      $display("FAIL pre_reset_load: got %h expected 4567", bcd0);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bcd0 !== 16'h0000 || lerr0 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got bcd=%h err=%b expected 0000 0", bcd0, lerr0);
    end
    #3 rst_n = 1'b1;
    en = 1'b1; up = 1'b1;
    #1;
    vectors++;
    if (cout0 !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_cout: got %b expected 0", cout0);
    end
    step();
    en = 1'b0;
    vectors++;
    if (bcd0 !== 16'h0001) begin
      miscompares++;
      $display("FAIL post_reset_count: got %h expected 0001", bcd0);
    end
  endtask

  task automatic test_digits8();
    load = 1'b1; din32 = 32'h9999_9999;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    vectors++;
    if (cout3 !== 1'b1) begin
      miscompares++;
      $display("FAIL d8_carry: got %b expected 1", cout3);
    end
    step();
    vectors++;
    if (bcd3 !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL d8_wrap_up: got %h expected 00000000", bcd3);
    end
    up = 1'b0;
    step();
    vectors++;
    if (bcd3 !== 32'h9999_9999) begin
      miscompares++;
      $display("FAIL d8_wrap_down: got %h expected 99999999", bcd3);
    end
    load = 1'b1; din32 = 32'h1000_0000;
    step();
    load = 1'b0;
    step();
    en = 1'b0;
    vectors++;
    if (bcd3 !== 32'h0999_9999) begin
      miscompares++;
      $display("FAIL d8_long_borrow: got %h expected 09999999", bcd3);
    end
    load = 1'b1; din4 = 4'h9; up = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    step();
    en = 1'b0;
    vectors++;
    if (bcd2 !== 4'h0) begin
      miscompares++;
      $display("FAIL d1_wrap: got %h expected 0", bcd2);
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_load_down();
    test_saturate();
    test_load_err();
    test_priority();
    test_hold();
    test_async_reset();
    test_digits8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
